// File: rtl/fpm_round_norm_if.sv
// ---------------------------------------------------------------------------
// fpm_round_norm_if
//
// Purpose
//    Bundles the upstream (product in) and downstream (packed result out)
//    valid/ready channels of the FP multiplier round/normalise stage so the
//    stage and its neighbours connect through one port.
//
// Signals
//    in_valid      producer offers a product this cycle
//    in_ready      stage can accept; transfer when in_valid && in_ready
//    in_sign       product sign (S1 ^ S2)
//    in_exp_sum    signed two's-complement E1 + E2 - 127
//    in_prod       raw 48-bit significand product {1.M1} * {1.M2}
//    in_is_nan     operand combination is inf*0 or a NaN operand
//    in_is_inf     an operand is infinite (non-NaN case)
//    in_is_zero    an operand is zero (non-NaN case)
//    out_valid     result held on out_* this cycle
//    out_ready     consumer accepts; transfer when out_valid && out_ready
//    out_result    packed IEEE-754 single {sign, exp[7:0], mant[22:0]}
//    out_overflow  result saturated to infinity
//    out_underflow result flushed to zero
//    out_inexact   a discarded bit was nonzero
//
// Modports
//    master  the surrounding system: drives in_*, out_ready
//    slave   the round/normalise stage: drives in_ready, out_*
// ---------------------------------------------------------------------------
interface fpm_round_norm_if;

   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [9:0]  in_exp_sum;
   logic [47:0] in_prod;
   logic        in_is_nan;
   logic        in_is_inf;
   logic        in_is_zero;

   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_overflow;
   logic        out_underflow;
   logic        out_inexact;

   modport master (
      output in_valid,
      input  in_ready,
      output in_sign,
      output in_exp_sum,
      output in_prod,
      output in_is_nan,
      output in_is_inf,
      output in_is_zero,
      input  out_valid,
      output out_ready,
      input  out_result,
      input  out_overflow,
      input  out_underflow,
      input  out_inexact
   );

   modport slave (
      input  in_valid,
      output in_ready,
      input  in_sign,
      input  in_exp_sum,
      input  in_prod,
      input  in_is_nan,
      input  in_is_inf,
      input  in_is_zero,
      output out_valid,
      input  out_ready,
      output out_result,
      output out_overflow,
      output out_underflow,
      output out_inexact
   );

endinterface

// File: rtl/fpm_round_norm.sv
// ---------------------------------------------------------------------------
// fpm_round_norm
//
// Purpose
//    Back-end stage of the single-precision FP multiplier. Takes the raw
//    48-bit significand product, the sign, the biased exponent sum and the
//    special-case flags, then normalises, rounds to nearest-even, handles
//    overflow/underflow and packs an IEEE-754 result.
//
//    Two registered stages with an elastic valid/ready handshake:
//       stage 1  normalise (pick leading one, extract mant/G/R/S)
//       stage 2  round, resolve specials/range, pack into out_*
//    Throughput is one item per clock; up to two items are buffered while
//    the consumer stalls.
//
// Parameters
//    FLUSH_DENORM  results with exponent <= 0 after rounding flush to signed
//                  zero; only the value 1 is supported
//    QNAN          pattern emitted for NaN results
//
// Ports
//    clk    rising-edge clock
//    rst_n  asynchronous active-low reset; discards all buffered items
//    bus    fpm_round_norm_if.slave - upstream in_* and downstream out_*
// ---------------------------------------------------------------------------
module fpm_round_norm #(
   parameter bit          FLUSH_DENORM = 1'b1,
   parameter logic [31:0] QNAN         = 32'h7FC0_0000
) (
   input  logic              clk,
   input  logic              rst_n,
   fpm_round_norm_if.slave   bus
);

   // ------------------------------------------------------------------
   // Stage 1 state (normalised significand plus rounding bits)
   // ------------------------------------------------------------------
   logic               s1_valid;
   logic               s1_sign;
   logic signed [9:0]  s1_exp;
   logic [22:0]        s1_mant;
   logic               s1_g;
   logic               s1_r;
   logic               s1_s;
   logic               s1_nan;
   logic               s1_inf;
   logic               s1_zero;

   // ------------------------------------------------------------------
   // Stage 2 state (the registered output)
   // ------------------------------------------------------------------
   logic               out_valid_q;
   logic [31:0]        out_result_q;
   logic               out_overflow_q;
   logic               out_underflow_q;
   logic               out_inexact_q;

   // ------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------
   logic               s2_load;
   logic               s1_load;

   // Stage 1 combinational results
   logic signed [9:0]  n_exp;
   logic [22:0]        n_mant;
   logic               n_g;
   logic               n_r;
   logic               n_s;

   // Stage 2 combinational results
   logic               round_up;
   logic [23:0]        m24;
   logic [22:0]        r_mant;
   logic signed [9:0]  r_exp;
   logic               r_inexact;
   logic [31:0]        nxt_result;
   logic               nxt_overflow;
   logic               nxt_underflow;
   logic               nxt_inexact;

   // The output register may load whenever it is empty or its current
   // item is being taken this cycle. Stage 1 drains into it on the same
   // condition, so in_ready only looks at register state and out_ready,
   // never at in_valid.
   assign s2_load      = !out_valid_q || bus.out_ready;
   assign s1_load      = !s1_valid || s2_load;
   assign bus.in_ready = s1_load;

   assign bus.out_valid     = out_valid_q;
   assign bus.out_result    = out_result_q;
   assign bus.out_overflow  = out_overflow_q;
   assign bus.out_underflow = out_underflow_q;
   assign bus.out_inexact   = out_inexact_q;

   // Normalisation: the product of two 1.x significands lies in [1,4), so
   // the leading one sits at bit 47 or bit 46. When it is at bit 47 the
   // value is shifted right one place and the exponent bumps by one.
   always_comb begin
      n_exp  = $signed(bus.in_exp_sum);
      n_mant = bus.in_prod[45:23];
      n_g    = bus.in_prod[22];
      n_r    = bus.in_prod[21];
      n_s    = |bus.in_prod[20:0];
      if (bus.in_prod[47]) begin
         n_exp  = $signed(bus.in_exp_sum) + 10'sd1;
         n_mant = bus.in_prod[46:24];
         n_g    = bus.in_prod[23];
         n_r    = bus.in_prod[22];
         n_s    = |bus.in_prod[21:0];
      end
   end

   // Round to nearest-even, then resolve specials and range. A carry out
   // of the 23-bit fraction means the significand became 10.000..., which
   // renormalises to 1.000... with the exponent one higher. The exponent
   // is compared after rounding so a carry can itself cause overflow.
   // Specials take priority over range checks and never raise flags.
   always_comb begin
      round_up  = s1_g & (s1_r | s1_s | s1_mant[0]);
      m24       = {1'b0, s1_mant} + {23'd0, round_up};
      r_mant    = m24[22:0];
      r_exp     = s1_exp;
      if (m24[23]) begin
         r_mant = 23'd0;
         r_exp  = s1_exp + 10'sd1;
      end
      r_inexact = s1_g | s1_r | s1_s;

      nxt_result    = {s1_sign, r_exp[7:0], r_mant};
      nxt_overflow  = 1'b0;
      nxt_underflow = 1'b0;
      nxt_inexact   = r_inexact;

      if (s1_nan) begin
         nxt_result  = QNAN;
         nxt_inexact = 1'b0;
      end else if (s1_inf) begin
         nxt_result  = {s1_sign, 8'hFF, 23'd0};
         nxt_inexact = 1'b0;
      end else if (s1_zero) begin
         nxt_result  = {s1_sign, 8'h00, 23'd0};
         nxt_inexact = 1'b0;
      end else if (r_exp >= 10'sd255) begin
         nxt_result   = {s1_sign, 8'hFF, 23'd0};
         nxt_overflow = 1'b1;
         nxt_inexact  = 1'b1;
      end else if (FLUSH_DENORM && (r_exp <= 10'sd0)) begin
         nxt_result    = {s1_sign, 8'h00, 23'd0};
         nxt_underflow = 1'b1;
         nxt_inexact   = 1'b1;
      end
   end

   // Stage 1 register. When it can load but nothing is offered it empties,
   // which is safe because its previous content has moved to stage 2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_sign  <= 1'b0;
         s1_exp   <= 10'sd0;
         s1_mant  <= 23'd0;
         s1_g     <= 1'b0;
         s1_r     <= 1'b0;
         s1_s     <= 1'b0;
         s1_nan   <= 1'b0;
         s1_inf   <= 1'b0;
         s1_zero  <= 1'b0;
      end else if (s1_load) begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            s1_sign <= bus.in_sign;
            s1_exp  <= n_exp;
            s1_mant <= n_mant;
            s1_g    <= n_g;
            s1_r    <= n_r;
            s1_s    <= n_s;
            s1_nan  <= bus.in_is_nan;
            s1_inf  <= bus.in_is_inf;
            s1_zero <= bus.in_is_zero;
         end
      end
   end

   // Output register. Data only changes when a real item moves in, so a
   // stalled result stays bit-stable and a bubble leaves the last value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q     <= 1'b0;
         out_result_q    <= 32'd0;
         out_overflow_q  <= 1'b0;
         out_underflow_q <= 1'b0;
         out_inexact_q   <= 1'b0;
      end else if (s2_load) begin
         out_valid_q <= s1_valid;
         if (s1_valid) begin
            out_result_q    <= nxt_result;
            out_overflow_q  <= nxt_overflow;
            out_underflow_q <= nxt_underflow;
            out_inexact_q   <= nxt_inexact;
         end
      end
   end

endmodule

// File: tb/tb_fpm_round_norm.sv
// ---------------------------------------------------------------------------
// tb_fpm_round_norm
//
// Directed bench for fpm_round_norm. Each scenario task drives its own
// vectors and compares against hand-computed IEEE-754 results.
// Flags are compared as {overflow, underflow, inexact}.
// ---------------------------------------------------------------------------
module tb_fpm_round_norm;

   logic clk;
   logic rst_n;

   int checks_total;
   int checks_passed;

   fpm_round_norm_if bus ();

   fpm_round_norm #(
      .FLUSH_DENORM (1'b1),
      .QNAN         (32'h7FC0_0000)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [47:0] P_B46   = 48'h4000_0000_0000;
   localparam logic [47:0] P_B47   = 48'h8000_0000_0000;
   localparam logic [47:0] P_CARRY = 48'hFFFF_FF80_0000;

   // Puts the input channel in its idle state.
   task automatic set_idle();
      bus.in_valid   = 1'b0;
      bus.in_sign    = 1'b0;
      bus.in_exp_sum = 10'd0;
      bus.in_prod    = 48'd0;
      bus.in_is_nan  = 1'b0;
      bus.in_is_inf  = 1'b0;
      bus.in_is_zero = 1'b0;
   endtask

   // Offers one item on the input channel.
   task automatic drive_item(input logic sgn, input logic [9:0] es, input logic [47:0] pr,
                             input logic nan, input logic inf, input logic zero);
      bus.in_valid   = 1'b1;
      bus.in_sign    = sgn;
      bus.in_exp_sum = es;
      bus.in_prod    = pr;
      bus.in_is_nan  = nan;
      bus.in_is_inf  = inf;
      bus.in_is_zero = zero;
   endtask

   // Sends one item into an empty pipeline and returns what appears on the
   // output plus the number of edges from acceptance (bounded at 8).
   // Called 1 time unit after a rising edge.
   task automatic send_one(input logic sgn, input logic [9:0] es, input logic [47:0] pr,
                           input logic nan, input logic inf, input logic zero,
                           output logic [31:0] res, output logic [2:0] flg, output int lat);
      bus.out_ready = 1'b1;
      drive_item(sgn, es, pr, nan, inf, zero);
      @(posedge clk); #1;
      set_idle();
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < 8) begin
         @(posedge clk); #1;
         lat++;
      end
      res = bus.out_result;
      flg = {bus.out_overflow, bus.out_underflow, bus.out_inexact};
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      set_idle();
      #2 rst_n = 1'b0;
      #2;
      checks_total++;
      if (bus.out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid);
      else checks_passed++;
      checks_total++;
      if (bus.out_result !== 32'd0) $display("[TB] FAIL reset_out_result: got %h expected 00000000", bus.out_result);
      else checks_passed++;
      checks_total++;
      if ({bus.out_overflow, bus.out_underflow, bus.out_inexact} !== 3'b000)
         $display("[TB] FAIL reset_flags: got %b expected 000", {bus.out_overflow, bus.out_underflow, bus.out_inexact});
      else checks_passed++;
      checks_total++;
      if (bus.in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready);
      else checks_passed++;
      @(posedge clk); @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks_total++;
      if (bus.out_valid !== 1'b0) $display("[TB] FAIL post_reset_idle: got %b expected 0", bus.out_valid);
      else checks_passed++;
   endtask

   task automatic test_normal();
      logic [31:0] res;
      logic [2:0]  flg;
      int          lat;
      // 2.0 * 4.0 = 8.0
      send_one(1'b0, 10'd130, P_B46, 1'b0, 1'b0, 1'b0, res, flg, lat);
      checks_total++;
      if (lat != 2) $display("[TB] FAIL latency_2x4: got %0d expected 2", lat);
      else checks_passed++;
      checks_total++;
      if (res !== 32'h4100_0000) $display("[TB] FAIL result_2x4: got %h expected 41000000", res);
      else checks_passed++;
      checks_total++;
      if (flg !== 3'b000) $display("[TB] FAIL flags_2x4: got %b expected 000", flg);
      else checks_passed++;
      // -2.0 * 4.0
      send_one(1'b1, 10'd130, P_B46, 1'b0, 1'b0, 1'b0, res, flg, lat);
      checks_total++;
      if (res !== 32'hC100_0000) $display("[TB] FAIL result_neg: got %h expected C1000000", res);
      else checks_passed++;
      // smallest normal exponent stays normal
      send_one(1'b0, 10'd1, P_B46, 1'b0, 1'b0, 1'b0, res, flg, lat);
      checks_total++;
      if ({res, flg} !== {32'h0080_0000, 3'b000})
         $display("[TB] FAIL exp_min_normal: got %h/%b expected 00800000/000", res, flg);
      else checks_passed++;
      // largest finite exponent via the bit47 path
      send_one(1'b0, 10'd253, P_B47, 1'b0, 1'b0, 1'b0, res, flg, lat);
      checks_total++;
      if ({res, flg} !== {32'h7F00_0000, 3'b000})
         $display("[TB] FAIL exp_max_finite: got %h/%b expected 7F000000/000", res, flg);
      else checks_passed++;
   endtask

   task automatic test_rounding();
      logic [31:0] res;
      logic [2:0]  flg;
      int          lat;
      // tie with even lsb stays
      send_one(1'b0, 10'd127, P_B46 | 48'h40_0000, 1'b0, 1'b0, 1'b0, res, flg, lat);
      checks_total++;
      if ({res, flg} !== {32'h3F80_0000, 3'b001})
         $display("[TB] FAIL tie_even: got %h/%b expected 3F800000/001", res, flg);
      else checks_passed++;
      // tie with odd lsb rounds up to even
      send_one(1'b0, 10'd127, P_B46 | 48'hC0_0000, 1'b0, 1'b0, 1'b0, res, flg, lat);
      checks_total++;
      if ({res, flg} !== {32'h3F80_0002, 3'b001})
         $display("[TB] FAIL tie_odd: got %h/%b expected 3F800002/001", res, flg);
      else checks_passed++;
      // above half via sticky rounds up
      send_one(1'b0, 10'd127, P_B46 | 48'h40_0001, 1'b0, 1'b0, 1'b0, res, flg, lat);
      checks_total++;
      if ({res, flg} !== {32'h3F80_0001, 3'b001})
         $display("[TB] FAIL sticky_up: got %h/%b expected 3F800001/001", res, flg);
      else checks_passed++;
      // below half truncates but is inexact
      send_one(1'b0, 10'd127, P_B46 | 48'h20_0000, 1'b0, 1'b0, 1'b0, res, flg, lat);
      checks_total++;
      if ({res, flg} !== {32'h3F80_0000, 3'b001})
         $display("[TB] FAIL below_half: got %h/%b expected 3F800000/001", res, flg);
      else checks_passed++;
      // rounding carry-out renormalises to 4.0
      send_one(1'b0, 10'd127, P_CARRY, 1'b0, 1'b0, 1'b0, res, flg, lat);
      checks_total++;
      if ({res, flg} !== {32'h4080_0000, 3'b001})
         $display("[TB] FAIL carry_out: got %h/%b expected 40800000/001", res, flg);
      else checks_passed++;
   endtask

   task automatic test_range();
      logic [31:0] res;
      logic [2:0]  flg;
      int          lat;
      send_one(1'b0, 10'd254, P_B47, 1'b0, 1'b0, 1'b0, res, flg, lat);
      checks_total++;
      if ({res, flg} !== {32'h7F80_0000, 3'b101})
         $display("[TB] FAIL overflow: got %h/%b expected 7F800000/101", res, flg);
      else checks_passed++;
      // carry out of rounding pushes 254 to 255
      send_one(1'b1, 10'd253, P_CARRY, 1'b0, 1'b0, 1'b0, res, flg, lat);
      checks_total++;
      if ({res, flg} !== {32'hFF80_0000, 3'b101})
         $display("[TB] FAIL carry_overflow: got %h/%b expected FF800000/101", res, flg);
      else checks_passed++;
      send_one(1'b0, 10'd0, P_B46, 1'b0, 1'b0, 1'b0, res, flg, lat);
      checks_total++;
      if ({res, flg} !== {32'h0000_0000, 3'b011})
         $display("[TB] FAIL underflow: got %h/%b expected 00000000/011", res, flg);
      else checks_passed++;
      // negative exponent sum (-5) with sign keeps signed zero
      send_one(1'b1, 10'h3FB, P_B47, 1'b0, 1'b0, 1'b0, res, flg, lat);
      checks_total++;
      if ({res, flg} !== {32'h8000_0000, 3'b011})
         $display("[TB] FAIL underflow_neg: got %h/%b expected 80000000/011", res, flg);
      else checks_passed++;
   endtask

   task automatic test_specials();
      logic [31:0] res;
      logic [2:0]  flg;
      int          lat;
      send_one(1'b1, 10'd130, P_B46 | 48'h1, 1'b1, 1'b0, 1'b0, res, flg, lat);
      checks_total++;
      if ({res, flg} !== {32'h7FC0_0000, 3'b000})
         $display("[TB] FAIL nan: got %h/%b expected 7FC00000/000", res, flg);
      else checks_passed++;
      // nan outranks inf
      send_one(1'b0, 10'd130, P_B46, 1'b1, 1'b1, 1'b0, res, flg, lat);
      checks_total++;
      if ({res, flg} !== {32'h7FC0_0000, 3'b000})
         $display("[TB] FAIL nan_priority: got %h/%b expected 7FC00000/000", res, flg);
      else checks_passed++;
      // inf outranks an exponent that would also overflow
      send_one(1'b1, 10'd300, P_B47 | 48'h1, 1'b0, 1'b1, 1'b0, res, flg, lat);
      checks_total++;
      if ({res, flg} !== {32'hFF80_0000, 3'b000})
         $display("[TB] FAIL inf_neg: got %h/%b expected FF800000/000", res, flg);
      else checks_passed++;
      send_one(1'b0, 10'd0, 48'd0, 1'b0, 1'b0, 1'b1, res, flg, lat);
      checks_total++;
      if ({res, flg} !== {32'h0000_0000, 3'b000})
         $display("[TB] FAIL zero: got %h/%b expected 00000000/000", res, flg);
      else checks_passed++;
      send_one(1'b1, 10'd127, P_B46 | 48'h40_0000, 1'b0, 1'b0, 1'b1, res, flg, lat);
      checks_total++;
      if ({res, flg} !== {32'h8000_0000, 3'b000})
         $display("[TB] FAIL zero_neg: got %h/%b expected 80000000/000", res, flg);
      else checks_passed++;
   endtask

   task automatic test_back_to_back();
      logic [9:0]  es  [3];
      logic [47:0] pr  [3];
      logic [31:0] exp_res [3];
      logic [31:0] got [8];
      int          n;
      int          first_c;
      es[0] = 10'd130; pr[0] = P_B46;                exp_res[0] = 32'h4100_0000;
      es[1] = 10'd127; pr[1] = P_B46 | 48'hC0_0000;  exp_res[1] = 32'h3F80_0002;
      es[2] = 10'd127; pr[2] = P_CARRY;              exp_res[2] = 32'h4080_0000;
      n = 0;
      first_c = -1;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 7; c++) begin
         if (c < 3) drive_item(1'b0, es[c], pr[c], 1'b0, 1'b0, 1'b0);
         else set_idle();
         #1;
         if (c < 3) begin
            checks_total++;
            if (bus.in_ready !== 1'b1) $display("[TB] FAIL b2b_in_ready_%0d: got %b expected 1", c, bus.in_ready);
            else checks_passed++;
         end
         @(posedge clk); #1;
         if (bus.out_valid === 1'b1 && n < 8) begin
            if (first_c < 0) first_c = c;
            got[n] = bus.out_result;
            n++;
         end
      end
      checks_total++;
      if (first_c != 1) $display("[TB] FAIL b2b_first_cycle: got %0d expected 1", first_c);
      else checks_passed++;
      checks_total++;
      if (n != 3) $display("[TB] FAIL b2b_count: got %0d expected 3", n);
      else checks_passed++;
      for (int i = 0; i < 3; i++) begin
         checks_total++;
         if (n <= i || got[i] !== exp_res[i])
            $display("[TB] FAIL b2b_result_%0d: got %h expected %h", i, (n > i) ? got[i] : 32'hx, exp_res[i]);
         else checks_passed++;
      end
   endtask

   task automatic test_backpressure();
      logic [9:0]  es  [3];
      logic [47:0] pr  [3];
      logic [31:0] exp_res [3];
      logic [31:0] got [8];
      int          idx;
      int          n;
      logic        rdy;
      es[0] = 10'd130; pr[0] = P_B46;                exp_res[0] = 32'h4100_0000;
      es[1] = 10'd127; pr[1] = P_B46 | 48'hC0_0000;  exp_res[1] = 32'h3F80_0002;
      es[2] = 10'd127; pr[2] = P_CARRY;              exp_res[2] = 32'h4080_0000;
      idx = 0;
      n = 0;
      bus.out_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (idx < 3) drive_item(1'b0, es[idx], pr[idx], 1'b0, 1'b0, 1'b0);
         else set_idle();
         #1 rdy = bus.in_ready;
         @(posedge clk);
         if (rdy && bus.in_valid) idx++;
         #1;
         if (c >= 2) begin
            checks_total++;
            if (bus.out_valid !== 1'b1 || bus.out_result !== exp_res[0])
               $display("[TB] FAIL stall_hold_%0d: got %b/%h expected 1/%h", c, bus.out_valid, bus.out_result, exp_res[0]);
            else checks_passed++;
         end
      end
      checks_total++;
      if (idx != 2) $display("[TB] FAIL stall_accepted: got %0d expected 2", idx);
      else checks_passed++;
      checks_total++;
      if (bus.in_ready !== 1'b0) $display("[TB] FAIL stall_in_ready: got %b expected 0", bus.in_ready);
      else checks_passed++;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         if (idx < 3) drive_item(1'b0, es[idx], pr[idx], 1'b0, 1'b0, 1'b0);
         else set_idle();
         #1 rdy = bus.in_ready;
         if (bus.out_valid === 1'b1 && n < 8) begin
            got[n] = bus.out_result;
            n++;
         end
         @(posedge clk);
         if (rdy && bus.in_valid) idx++;
         #1;
      end
      set_idle();
      checks_total++;
      if (n != 3) $display("[TB] FAIL release_count: got %0d expected 3", n);
      else checks_passed++;
      for (int i = 0; i < 3; i++) begin
         checks_total++;
         if (n <= i || got[i] !== exp_res[i])
            $display("[TB] FAIL release_order_%0d: got %h expected %h", i, (n > i) ? got[i] : 32'hx, exp_res[i]);
         else checks_passed++;
      end
   endtask

   task automatic test_reset_midflight();
      logic [31:0] res;
      logic [2:0]  flg;
      int          lat;
      bus.out_ready = 1'b1;
      drive_item(1'b0, 10'd130, P_B46, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      drive_item(1'b0, 10'd127, P_CARRY, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      set_idle();
      checks_total++;
      if (bus.out_valid !== 1'b1) $display("[TB] FAIL inflight_valid: got %b expected 1", bus.out_valid);
      else checks_passed++;
      rst_n = 1'b0;
      #1;
      checks_total++;
      if (bus.out_valid !== 1'b0 || bus.out_result !== 32'd0)
         $display("[TB] FAIL async_reset: got %b/%h expected 0/00000000", bus.out_valid, bus.out_result);
      else checks_passed++;
      @(posedge clk); #2;
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         checks_total++;
         if (bus.out_valid !== 1'b0) $display("[TB] FAIL no_stale_%0d: got %b expected 0", c, bus.out_valid);
         else checks_passed++;
      end
      send_one(1'b0, 10'd127, P_B46 | 48'h40_0000, 1'b0, 1'b0, 1'b0, res, flg, lat);
      checks_total++;
      if (lat != 2) $display("[TB] FAIL resume_latency: got %0d expected 2", lat);
      else checks_passed++;
      checks_total++;
      if (res !== 32'h3F80_0000) $display("[TB] FAIL resume_result: got %h expected 3F800000", res);
      else checks_passed++;
   endtask

   initial begin
      checks_total  = 0;
      checks_passed = 0;
      test_reset();
      test_normal();
      test_rounding();
      test_range();
      test_specials();
      test_back_to_back();
      test_backpressure();
      test_reset_midflight();
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
